// File: rtl/hex_pkg.sv
// ---------------------------------------------------------------------------
// hex_pkg
// Shared constants and small helpers for the multiplexed hex display driver.
//   NUM_DIGITS   : number of scanned digits
//   NUM_PHASES   : PWM sub-phases per digit slot
//   SEG_OFF      : active-low segment pattern with every segment dark
//   digit_t      : digit index type
//   phase_t      : sub-phase index type
//   digit_select : one-hot (active-high) select for a digit index
// ---------------------------------------------------------------------------
package hex_pkg;

    localparam int         NUM_DIGITS = 6;
    localparam int         NUM_PHASES = 16;
    localparam logic [7:0] SEG_OFF    = 8'hFF;

    typedef logic [2:0] digit_t;
    typedef logic [3:0] phase_t;

    // One-hot select; an out-of-range index selects nothing.
    function automatic logic [NUM_DIGITS-1:0] digit_select(input digit_t idx);
        logic [NUM_DIGITS-1:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_t'(i) == idx) sel[i] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/scan_tick.sv
// ---------------------------------------------------------------------------
// scan_tick
// Counter chain for the display scan: sub-cycle counter sc (0..SUB_CYCLES-1),
// sub-phase ph (0..15) and digit index di (0..5), plus the strobes that the
// driver needs to line its registers up with slot and frame boundaries.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset (already release-synchronised)
//   di          : current digit index
//   ph_next     : sub-phase the counters move to on the coming edge
//   di_next     : digit index the counters move to on the coming edge
//   slot_start  : first cycle of a slot (ph=0, sc=0)
//   slot_end    : last cycle of a slot (ph=15, sc=SUB_CYCLES-1)
//   capture     : last cycle of a frame (slot_end of digit 5)
//   frame_start : registered capture, high for the first cycle of each frame
// ---------------------------------------------------------------------------
module scan_tick
    import hex_pkg::*;
#(
    parameter int SUB_CYCLES = 32
)(
    input  logic   clk,
    input  logic   rst_n,
    output digit_t di,
    output phase_t ph_next,
    output digit_t di_next,
    output logic   slot_start,
    output logic   slot_end,
    output logic   capture,
    output logic   frame_start
);

    localparam logic [15:0] SC_LAST = 16'(SUB_CYCLES - 1);

    logic [15:0] sc;
    logic [15:0] sc_next;
    phase_t      ph;

    // Ripple-carry style chain: ph only moves when sc wraps, di only when
    // both sc and ph wrap.
    always_comb begin
        sc_next = sc + 16'd1;
        ph_next = ph;
        di_next = di;
        if (sc == SC_LAST) begin
            sc_next = '0;
            if (ph == phase_t'(NUM_PHASES - 1)) begin
                ph_next = '0;
                di_next = (di == digit_t'(NUM_DIGITS - 1)) ? '0 : di + 3'd1;
            end else begin
                ph_next = ph + 4'd1;
            end
        end
    end

    // The frame pulse is the capture strobe delayed by one cycle so it
    // lands on the first cycle of digit 0, never on the post-reset start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc          <= '0;
            ph          <= '0;
            di          <= '0;
            frame_start <= 1'b0;
        end else begin
            sc          <= sc_next;
            ph          <= ph_next;
            di          <= di_next;
            frame_start <= capture;
        end
    end

    assign slot_start = (sc == '0) && (ph == '0);
    assign slot_end   = (sc == SC_LAST) && (ph == phase_t'(NUM_PHASES - 1));
    assign capture    = slot_end && (di == digit_t'(NUM_DIGITS - 1));

endmodule

// File: rtl/hex_scan_drv.sv
// ---------------------------------------------------------------------------
// hex_scan_drv
// Time-multiplexed six-digit seven-segment driver with 16-step PWM dimming.
// Segment data is frozen per frame in a snapshot so a frame never mixes old
// and new digits; sub-phase 0 of every slot is dead time so the shared
// segment bus only changes while all digits are dark.
//   clk            : system clock
//   rst            : asynchronous active-low reset (release synchronised)
//   sthex0..5      : active-low segment patterns {dp,g,f,e,d,c,b,a}
//   bright         : brightness 0..15 (enabled sub-phases per slot)
//   en             : display enable, 0 blanks the digits
//   seg            : shared segment bus, polarity per SEG_ACTIVE_LOW
//   dig            : digit enables, polarity per DIG_ACTIVE_LOW
//   frame          : one-cycle pulse on the first cycle of each frame
// ---------------------------------------------------------------------------
module hex_scan_drv
    import hex_pkg::*;
#(
    parameter int SUB_CYCLES     = 32,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            sthex0,
    input  logic [7:0]            sthex1,
    input  logic [7:0]            sthex2,
    input  logic [7:0]            sthex3,
    input  logic [7:0]            sthex4,
    input  logic [7:0]            sthex5,
    input  logic [3:0]            bright,
    input  logic                  en,
    output logic [7:0]            seg,
    output logic [NUM_DIGITS-1:0] dig,
    output logic                  frame
);

    localparam logic [7:0]            SEG_IDLE = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] DIG_IDLE = DIG_ACTIVE_LOW ? '1 : '0;

    logic [1:0]                  rst_pipe;
    logic                        rst_int;
    digit_t                      di;
    phase_t                      ph_next;
    digit_t                      di_next;
    logic                        slot_start;
    logic                        slot_end;
    logic                        capture;
    logic                        frame_start;
    logic [NUM_DIGITS-1:0][7:0]  snap;
    logic [3:0]                  bright_l;
    logic                        en_l;
    logic [NUM_DIGITS-1:0]       dig_next;

    // Assertion is immediate (async clear), release goes through two flops,
    // so the internal reset drops after the second edge following release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_pipe <= '0;
        else      rst_pipe <= {rst_pipe[0], 1'b1};
    end

    assign rst_int = rst_pipe[1];

    scan_tick #(
        .SUB_CYCLES (SUB_CYCLES)
    ) u_tick (
        .clk         (clk),
        .rst_n       (rst_int),
        .di          (di),
        .ph_next     (ph_next),
        .di_next     (di_next),
        .slot_start  (slot_start),
        .slot_end    (slot_end),
        .capture     (capture),
        .frame_start (frame_start)
    );

    // Frame snapshot plus per-slot brightness/enable latches. bright and en
    // are taken on the ph 15->0 edge so a slot never changes duty midway.
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            snap     <= {NUM_DIGITS{SEG_OFF}};
            bright_l <= '0;
            en_l     <= 1'b0;
        end else begin
            if (capture) snap <= {sthex5, sthex4, sthex3, sthex2, sthex1, sthex0};
            if (slot_end) begin
                bright_l <= bright;
                en_l     <= en;
            end
        end
    end

    // Digit enable for the cycle after the coming edge, computed from the
    // next counter state so dig lines up exactly with ph. ph=0 never enables.
    always_comb begin
        dig_next = DIG_IDLE;
        if (en_l && (ph_next != '0) && (ph_next <= bright_l)) begin
            dig_next = DIG_ACTIVE_LOW ? ~digit_select(di_next) : digit_select(di_next);
        end
    end

    // seg is reloaded at the end of the first dead-time cycle of each slot,
    // which also picks up a fresh snapshot one cycle after the frame pulse.
    always_ff @(posedge clk or negedge rst_int) begin
        if (!rst_int) begin
            seg <= SEG_IDLE;
            dig <= DIG_IDLE;
        end else begin
            if (slot_start) seg <= SEG_ACTIVE_LOW ? snap[di] : ~snap[di];
            dig <= dig_next;
        end
    end

    assign frame = frame_start;

endmodule

// File: tb/tb_hex_scan_drv.sv
// ---------------------------------------------------------------------------
// tb_hex_scan_drv
// Self-checking bench for hex_scan_drv (SUB_CYCLES=2, active-high segments,
// active-low digits). A position-based model derives expected seg/dig/frame
// from the count of scan cycles since reset release, using per-slot and
// per-frame records of the inputs seen at each boundary.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hex_scan_drv;

    localparam int         SUB      = 2;
    localparam int         SLOT     = 16 * SUB;
    localparam int         FRAME    = 6 * SLOT;
    localparam bit         SEG_AL   = 1'b0;
    localparam bit         DIG_AL   = 1'b1;
    localparam logic [7:0] SEG_IDLE = SEG_AL ? 8'hFF : 8'h00;
    localparam logic [5:0] DIG_IDLE = DIG_AL ? 6'h3F : 6'h00;
    localparam int         MAX_SLOTS  = 1024;
    localparam int         MAX_FRAMES = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sthex [0:5];
    logic [3:0] bright;
    logic       en;
    logic [7:0] seg;
    logic [5:0] dig;
    logic       frame;
    logic       check_en = 1'b0;

    int assert_count = 0;
    int fail_count   = 0;

    // Model state: edges since release and the inputs seen at boundaries.
    int         rel_count = 0;
    int         slot_bright [0:MAX_SLOTS-1];
    bit         slot_en     [0:MAX_SLOTS-1];
    logic [7:0] frame_snap  [0:MAX_FRAMES-1][0:5];

    hex_scan_drv #(
        .SUB_CYCLES     (SUB),
        .SEG_ACTIVE_LOW (SEG_AL),
        .DIG_ACTIVE_LOW (DIG_AL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sthex0 (sthex[0]),
        .sthex1 (sthex[1]),
        .sthex2 (sthex[2]),
        .sthex3 (sthex[3]),
        .sthex4 (sthex[4]),
        .sthex5 (sthex[5]),
        .bright (bright),
        .en     (en),
        .seg    (seg),
        .dig    (dig),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    // Scan position: counting starts two edges after release.
    function automatic int count_now();
        return (rel_count >= 2) ? rel_count - 2 : 0;
    endfunction

    // Record bright/en at each slot entry and the inputs at each frame entry.
    always @(posedge clk) begin : model_update
        int next_rel;
        int next_cnt;
        next_rel = rst ? rel_count + 1 : 0;
        next_cnt = (next_rel >= 2) ? next_rel - 2 : 0;
        rel_count <= next_rel;
        if (next_cnt > 0 && next_cnt % SLOT == 0 && next_cnt / SLOT < MAX_SLOTS) begin
            slot_bright[next_cnt / SLOT] <= int'(bright);
            slot_en[next_cnt / SLOT]     <= en;
        end
        if (next_cnt > 0 && next_cnt % FRAME == 0 && next_cnt / FRAME < MAX_FRAMES) begin
            for (int i = 0; i < 6; i++) frame_snap[next_cnt / FRAME][i] <= sthex[i];
        end
    end

    // seg shows the frame's snapshot for the slot's digit; during the first
    // cycle of a slot it still shows the previous slot's byte.
    function automatic logic [7:0] exp_seg(input int c);
        int         p;
        int         s;
        logic [7:0] pat;
        p = (c > 0 && c % SLOT == 0) ? c - 1 : c;
        if (p == 0) return SEG_IDLE;
        s   = p / SLOT;
        pat = (s / 6 == 0) ? 8'hFF : frame_snap[s / 6][s % 6];
        return SEG_AL ? pat : ~pat;
    endfunction

    function automatic logic [5:0] exp_dig(input int c);
        int         s;
        int         ph;
        int         b;
        bit         e;
        logic [5:0] sel;
        s  = c / SLOT;
        ph = (c / SUB) % 16;
        b  = (s == 0) ? 0 : slot_bright[s];
        e  = (s == 0) ? 1'b0 : slot_en[s];
        if (e && ph >= 1 && ph <= b) begin
            sel = 6'b000001 << (s % 6);
            return DIG_AL ? ~sel : sel;
        end
        return DIG_IDLE;
    endfunction

    function automatic logic exp_frame(input int c);
        return (c > 0) && (c % FRAME == 0);
    endfunction

    function automatic int exp_duty(input int s);
        if (s == 0 || !slot_en[s]) return 0;
        return slot_bright[s] * SUB;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [7:0] value,
                                 input logic [3:0] new_bright, input logic new_en);
        if (idx >= 0 && idx < 6) sthex[idx] = value;
        bright = new_bright;
        en     = new_en;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for a given position within the frame.
    task automatic waitForPos(input int pos);
        for (int k = 0; k <= FRAME && (count_now() % FRAME) != pos; k++) @(negedge clk);
        checkOutput("wait_pos", count_now() % FRAME, pos);
    endtask

    // Per-cycle checks on the falling edge, plus slot duty and frame spacing.
    task automatic monitorLoop();
        int         on_cycles  = 0;
        int         cycle      = 0;
        int         last_frame = -1;
        int         c;
        logic [5:0] active;
        forever begin
            @(negedge clk);
            if (check_en) begin
                c      = count_now();
                active = DIG_AL ? ~dig : dig;
                checkOutput("seg", seg, exp_seg(c));
                checkOutput("dig", dig, exp_dig(c));
                checkOutput("frame", frame, exp_frame(c));
                checkOutput("dig_onehot0", 32'($countones(active) <= 1), 1);
                if (active != '0) on_cycles++;
                if (frame === 1'b1) begin
                    if (last_frame >= 0) checkOutput("frame_period", cycle - last_frame, FRAME);
                    last_frame = cycle;
                end
                if (c % SLOT == SLOT - 1) begin
                    checkOutput("slot_duty", on_cycles, exp_duty(c / SLOT));
                    on_cycles = 0;
                end
            end
            if (!rst) begin
                on_cycles  = 0;
                last_frame = -1;
            end
            cycle++;
        end
    endtask

    initial begin
        int sweep [0:2];
        int edges;
        bit found;
        sweep = '{0, 1, 8};

        sthex[0] = 8'hC0; sthex[1] = 8'hF9; sthex[2] = 8'hA4;
        sthex[3] = 8'hB0; sthex[4] = 8'h99; sthex[5] = 8'h92;
        bright = 4'd15;
        en     = 1'b1;

        fork
            monitorLoop();
        join_none

        #1 rst = 1'b0;
        check_en = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_seg", seg, SEG_IDLE);
        checkOutput("reset_dig", dig, DIG_IDLE);
        checkOutput("reset_frame", frame, 0);

        // Digit table at full brightness.
        @(negedge clk);
        #2 rst = 1'b1;
        waitCycles(3 * FRAME);

        // Mid-frame change of digit 2 must wait for the next frame.
        waitForPos(SLOT + SLOT / 2);
        applyStimulus(2, 8'(($urandom & 8'h7F) | 8'h01), bright, en);
        waitCycles(2 * FRAME);

        // Brightness sweep.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(-1, 8'h00, 4'(sweep[i]), 1'b1);
            waitCycles(FRAME);
        end

        // Blank for a frame, then re-enable mid-slot.
        applyStimulus(-1, 8'h00, 4'd9, 1'b0);
        waitCycles(FRAME + SLOT / 3);
        applyStimulus(-1, 8'h00, 4'd9, 1'b1);
        waitCycles(FRAME);

        // Random input activity at arbitrary times.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0)
                applyStimulus(-1, 8'h00, 4'($urandom_range(0, 15)), en);
            if ($urandom_range(0, 59) == 0)
                applyStimulus(-1, 8'h00, bright, ~en);
            if ($urandom_range(0, 49) == 0)
                applyStimulus(int'($urandom_range(0, 5)), 8'($urandom), bright, en);
        end
        applyStimulus(-1, 8'h00, 4'd12, 1'b1);

        // Reset in the middle of a slot blanks before any clock edge.
        waitForPos(2 * SLOT + 10);
        #2 rst = 1'b0;
        #1;
        checkOutput("midreset_seg", seg, SEG_IDLE);
        checkOutput("midreset_dig", dig, DIG_IDLE);
        checkOutput("midreset_frame", frame, 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // First frame pulse after release, bounded.
        edges = 0;
        found = 1'b0;
        while (!found && edges < 3 * FRAME) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (frame === 1'b1) found = 1'b1;
        end
        checkOutput("release_to_frame", edges, FRAME + 2);
        waitCycles(2 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
